snake_body_tracker: RTL and testbench

// Holds the snake's segment coordinates and advances them one grid cell per move tick.

---
 rtl/snake_pkg.sv | 56 +++++
 rtl/snake_body_tracker_if.sv | 47 ++++
 rtl/snake_next_head.sv | 45 ++++
 rtl/snake_body_tracker.sv | 115 +++++++++++
 tb/tb_snake_body_tracker.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared types and sizing for the snake body tracker.
// The grid and storage sizes live here as localparams. Keeping them in one
// place means point_t, the interface and the tracker always agree on widths.
// Contents:
//   GRID_W, GRID_H, MAX_LEN, INIT_LEN  grid size, storage depth, start length
//   XW, YW, LW                         coordinate and length widths
//   dir_t                              movement direction
//   point_t                            one grid cell (x, y)
//   opposite()                         the 180-degree reverse of a direction
//   init_point()                       start-of-game position of segment idx
// ---------------------------------------------------------------------------
package snake_pkg;

    localparam int GRID_W   = 32;
    localparam int GRID_H   = 24;
    localparam int MAX_LEN  = 64;
    localparam int INIT_LEN = 3;

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } point_t;

    // The encoding puts opposite directions two apart, so flipping bit 1
    // gives the reverse direction.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

    // A new snake lies horizontally in the middle of the grid, head at the
    // centre and body trailing to the left. Unused slots are parked at 0.
    function automatic point_t init_point(input int idx);
        point_t p;
        p.x = '0;
        p.y = '0;
        if (idx < INIT_LEN) begin
            p.x = XW'(GRID_W / 2 - idx);
            p.y = YW'(GRID_H / 2);
        end
        return p;
    endfunction

endpackage

// File: rtl/snake_body_tracker_if.sv
// ---------------------------------------------------------------------------
// snake_body_tracker_if
// Bundles the control, render-query and status signals of the tracker.
// Signals:
//   playing_i    game running; rising edge starts a new game
//   step_i       move tick, one-cycle pulse
//   dir_i        requested direction
//   dir_valid_i  dir_i valid this cycle
//   grow_i       food eaten, one-cycle pulse
//   query_x_i/y  render query cell
//   query_hit_o  query cell occupied (one cycle latency)
//   head_x_o/y   current head position
//   length_o     current length
//   collision_o  one-cycle collision pulse
// Modports:
//   master  game logic / renderer side
//   slave   tracker side
// ---------------------------------------------------------------------------
interface snake_body_tracker_if;
    import snake_pkg::*;

    logic          playing_i;
    logic          step_i;
    dir_t          dir_i;
    logic          dir_valid_i;
    logic          grow_i;
    logic [XW-1:0] query_x_i;
    logic [YW-1:0] query_y_i;
    logic          query_hit_o;
    logic [XW-1:0] head_x_o;
    logic [YW-1:0] head_y_o;
    logic [LW-1:0] length_o;
    logic          collision_o;

    modport master (
        output playing_i, step_i, dir_i, dir_valid_i, grow_i,
               query_x_i, query_y_i,
        input  query_hit_o, head_x_o, head_y_o, length_o, collision_o
    );

    modport slave (
        input  playing_i, step_i, dir_i, dir_valid_i, grow_i,
               query_x_i, query_y_i,
        output query_hit_o, head_x_o, head_y_o, length_o, collision_o
    );

endinterface

// File: rtl/snake_next_head.sv
// ---------------------------------------------------------------------------
// snake_next_head
// Combinational: where the head lands after one move, and whether that move
// would leave the grid.
// Ports:
//   head      current head cell
//   dir       direction of the move
//   nxt       head cell after the move (equals head on a wall hit)
//   wall_hit  the move would cross the grid border
// ---------------------------------------------------------------------------
module snake_next_head
    import snake_pkg::*;
(
    input  point_t head,
    input  dir_t   dir,
    output point_t nxt,
    output logic   wall_hit
);

    // Check the border before touching the coordinate, so a blocked move
    // never wraps round to the far side of the grid.
    always_comb begin
        nxt      = head;
        wall_hit = 1'b0;
        unique case (dir)
            UP: begin
                if (head.y == '0) wall_hit = 1'b1;
                else              nxt.y    = head.y - 1'b1;
            end
            DOWN: begin
                if (head.y == YW'(GRID_H - 1)) wall_hit = 1'b1;
                else                           nxt.y    = head.y + 1'b1;
            end
            LEFT: begin
                if (head.x == '0) wall_hit = 1'b1;
                else              nxt.x    = head.x - 1'b1;
            end
            RIGHT: begin
                if (head.x == XW'(GRID_W - 1)) wall_hit = 1'b1;
                else                           nxt.x    = head.x + 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/snake_body_tracker.sv
// ---------------------------------------------------------------------------
// snake_body_tracker
// Holds the snake's segment coordinates and advances them one cell per move
// tick. Turns requested into a 180-degree reversal are dropped. The module
// grows the snake on food and flags wall and self collisions.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous, active-high reset
//   bus      snake_body_tracker_if.slave (control, query and status)
// ---------------------------------------------------------------------------
module snake_body_tracker
    import snake_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       reset_i,
    snake_body_tracker_if.slave        bus
);

    point_t        seg [MAX_LEN];
    logic [LW-1:0] length_q;
    dir_t          cur_dir;
    dir_t          pend_dir;
    logic          grow_pend;
    logic          dead;
    logic          collision_q;
    logic          query_hit_q;
    logic          playing_q;

    point_t        nxt;
    logic          wall_hit;
    logic          self_hit;
    logic          query_match;
    logic          new_game;
    logic          step_ok;
    logic          can_grow;
    logic          hit;

    snake_next_head u_next_head (
        .head     (seg[0]),
        .dir      (pend_dir),
        .nxt      (nxt),
        .wall_hit (wall_hit)
    );

    // A grow pulse that arrives with the step counts for that step. At full
    // length the grow is thrown away, so the tail still vacates its cell.
    assign new_game = reset_i | (bus.playing_i & ~playing_q);
    assign step_ok  = bus.step_i & bus.playing_i & ~dead;
    assign can_grow = (grow_pend | bus.grow_i) & (length_q < LW'(MAX_LEN));
    assign hit      = wall_hit | self_hit;

    // Compare every live segment in parallel. This gives the self-hit test
    // for the move in progress and the render query. The tail slot is
    // exempt from the self-hit test unless the snake is growing, because
    // the tail moves out of that cell in the same step.
    always_comb begin
        self_hit    = 1'b0;
        query_match = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) < length_q) begin
                if (bus.query_x_i == seg[i].x && bus.query_y_i == seg[i].y)
                    query_match = 1'b1;
                if (nxt == seg[i] && !(LW'(i) == length_q - 1'b1 && !can_grow))
                    self_hit = 1'b1;
            end
        end
    end

    // Main state register. A new game (reset or a playing rising edge)
    // overrides everything else. Direction and grow requests are still
    // registered while the game is paused. An accepted step either kills
    // the snake or shifts the body one slot and places the new head.
    always_ff @(posedge clk_i) begin
        playing_q <= bus.playing_i;
        if (new_game) begin
            for (int i = 0; i < MAX_LEN; i++)
                seg[i] <= init_point(i);
            length_q    <= LW'(INIT_LEN);
            cur_dir     <= RIGHT;
            pend_dir    <= RIGHT;
            grow_pend   <= 1'b0;
            dead        <= 1'b0;
            collision_q <= 1'b0;
            query_hit_q <= 1'b0;
        end else begin
            collision_q <= 1'b0;
            query_hit_q <= query_match;
            if (bus.dir_valid_i && bus.dir_i != opposite(cur_dir))
                pend_dir <= bus.dir_i;
            if (step_ok) begin
                grow_pend <= 1'b0;
                if (hit) begin
                    dead        <= 1'b1;
                    collision_q <= 1'b1;
                end else begin
                    for (int i = MAX_LEN - 1; i > 0; i--)
                        seg[i] <= seg[i-1];
                    seg[0]  <= nxt;
                    cur_dir <= pend_dir;
                    if (can_grow)
                        length_q <= length_q + 1'b1;
                end
            end else if (bus.grow_i) begin
                grow_pend <= 1'b1;
            end
        end
    end

    assign bus.head_x_o    = seg[0].x;
    assign bus.head_y_o    = seg[0].y;
    assign bus.length_o    = length_q;
    assign bus.collision_o = collision_q;
    assign bus.query_hit_o = query_hit_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// ---------------------------------------------------------------------------
// tb_snake_body_tracker
// Directed test of snake_body_tracker. The bench drives inputs on the
// falling clock edge and checks outputs on the next falling edge, one
// rising edge later.
// ---------------------------------------------------------------------------
module tb_snake_body_tracker;
    import snake_pkg::*;

    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    snake_body_tracker_if bus ();

    snake_body_tracker dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    typedef struct {
        logic  step;
        logic  grow;
        logic  dv;
        dir_t  dir;
        int    hx;
        int    hy;
        int    len;
        logic  col;
    } vec_t;

    vec_t table_v [13];

    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_x;
    int   exp_y;
    int   exp_len;
    dir_t model_dir;

    // One full clock: through the rising edge, back to the falling edge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Drive one cycle of inputs, then drop the pulse-type inputs.
    task automatic applyStimulus(input logic step, input logic grow,
                                 input logic dv, input dir_t dir);
        bus.step_i      = step;
        bus.grow_i      = grow;
        bus.dir_valid_i = dv;
        bus.dir_i       = dir;
        tick();
        bus.step_i      = 1'b0;
        bus.grow_i      = 1'b0;
        bus.dir_valid_i = 1'b0;
    endtask

    // Compare head, length and the collision pulse with expected values.
    task automatic checkOutput(input string name, input int hx, input int hy,
                               input int len, input logic col);
        vectors++;
        if ($isunknown({bus.head_x_o, bus.head_y_o, bus.length_o, bus.collision_o}) ||
            int'(bus.head_x_o) != hx || int'(bus.head_y_o) != hy ||
            int'(bus.length_o) != len || bus.collision_o != col) begin
            miscompares++;
            $display("[TB] FAIL %s: got head=(%0d,%0d) len=%0d col=%b, want head=(%0d,%0d) len=%0d col=%b",
                     name, bus.head_x_o, bus.head_y_o, bus.length_o, bus.collision_o,
                     hx, hy, len, col);
        end
    endtask

    // Compare query_hit_o with the expected value.
    task automatic checkQuery(input string name, input logic expv);
        vectors++;
        if (bus.query_hit_o !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got query_hit=%b, want %b", name, bus.query_hit_o, expv);
        end
    endtask

    // Drop playing_i for a cycle and raise it again. The bench model goes
    // back to the start layout.
    task automatic newGame(input string name);
        bus.playing_i = 1'b0;
        tick();
        bus.playing_i = 1'b1;
        tick();
        exp_x     = 16;
        exp_y     = 12;
        exp_len   = 3;
        model_dir = RIGHT;
        checkOutput(name, 16, 12, 3, 1'b0);
    endtask

    // Turn if needed (in its own cycle), then step once. Unless a collision
    // is expected, the model head moves one cell and the length grows up to
    // MAX_LEN.
    task automatic doStep(input string name, input dir_t dir, input logic grow,
                          input logic exp_col);
        if (dir != model_dir) begin
            applyStimulus(1'b0, 1'b0, 1'b1, dir);
            model_dir = dir;
        end
        applyStimulus(1'b1, grow, 1'b0, dir);
        if (!exp_col) begin
            case (dir)
                UP:    exp_y--;
                DOWN:  exp_y++;
                LEFT:  exp_x--;
                RIGHT: exp_x++;
            endcase
            if (grow && exp_len < MAX_LEN) exp_len++;
        end
        checkOutput(name, exp_x, exp_y, exp_len, exp_col);
    endtask

    initial begin
        // Walk right, drop a reversal, turn up, let the last request before
        // a step win, then grow in and after the step cycle.
        table_v[0]  = '{1'b1, 1'b0, 1'b0, RIGHT, 17, 12, 3, 1'b0};
        table_v[1]  = '{1'b1, 1'b0, 1'b0, RIGHT, 18, 12, 3, 1'b0};
        table_v[2]  = '{1'b1, 1'b0, 1'b0, RIGHT, 19, 12, 3, 1'b0};
        table_v[3]  = '{1'b0, 1'b0, 1'b1, LEFT,  19, 12, 3, 1'b0};
        table_v[4]  = '{1'b1, 1'b0, 1'b0, RIGHT, 20, 12, 3, 1'b0};
        table_v[5]  = '{1'b0, 1'b0, 1'b1, UP,    20, 12, 3, 1'b0};
        table_v[6]  = '{1'b1, 1'b0, 1'b0, RIGHT, 20, 11, 3, 1'b0};
        table_v[7]  = '{1'b0, 1'b0, 1'b1, LEFT,  20, 11, 3, 1'b0};
        table_v[8]  = '{1'b0, 1'b0, 1'b1, RIGHT, 20, 11, 3, 1'b0};
        table_v[9]  = '{1'b1, 1'b0, 1'b0, RIGHT, 21, 11, 3, 1'b0};
        table_v[10] = '{1'b1, 1'b1, 1'b0, RIGHT, 22, 11, 4, 1'b0};
        table_v[11] = '{1'b0, 1'b1, 1'b0, RIGHT, 22, 11, 4, 1'b0};
        table_v[12] = '{1'b1, 1'b0, 1'b0, RIGHT, 23, 11, 5, 1'b0};

        reset_i         = 1'b1;
        bus.playing_i   = 1'b0;
        bus.step_i      = 1'b0;
        bus.grow_i      = 1'b0;
        bus.dir_valid_i = 1'b0;
        bus.dir_i       = RIGHT;
        bus.query_x_i   = '0;
        bus.query_y_i   = '0;
        model_dir       = RIGHT;
        @(negedge clk_i);
        tick();
        tick();
        checkOutput("reset", 16, 12, 3, 1'b0);
        checkQuery("reset_query", 1'b0);

        // Body cell next to the head is occupied straight after reset.
        reset_i       = 1'b0;
        bus.query_x_i = 5'd15;
        bus.query_y_i = 5'd12;
        tick();
        checkQuery("query_body_after_reset", 1'b1);

        bus.playing_i = 1'b1;
        tick();
        checkOutput("start_game", 16, 12, 3, 1'b0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(table_v[i].step, table_v[i].grow, table_v[i].dv, table_v[i].dir);
            checkOutput($sformatf("table_%0d", i), table_v[i].hx, table_v[i].hy,
                        table_v[i].len, table_v[i].col);
        end

        // A step while paused is ignored.
        bus.playing_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, RIGHT);
        checkOutput("paused_step", 23, 11, 5, 1'b0);

        // The query samples the segments from before the update, so the
        // new head shows up one cycle later.
        newGame("new_game_1");
        bus.query_x_i = 5'd17;
        bus.query_y_i = 5'd12;
        tick();
        checkQuery("query_empty", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, RIGHT);
        checkQuery("query_pre_update", 1'b0);
        tick();
        checkQuery("query_post_update", 1'b1);

        // Serpentine with a grow on every step: 61 grows take length 3 to
        // 64, and the next grow at full length is discarded.
        newGame("new_game_2");
        for (int i = 0; i < 14; i++) doStep("serp_r1", RIGHT, 1'b1, 1'b0);
        doStep("serp_u1", UP, 1'b1, 1'b0);
        for (int i = 0; i < 29; i++) doStep("serp_l", LEFT, 1'b1, 1'b0);
        doStep("serp_u2", UP, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) doStep("serp_r2", RIGHT, 1'b1, 1'b0);
        checkOutput("len_max", 17, 10, 64, 1'b0);
        doStep("grow_at_max", RIGHT, 1'b1, 1'b0);
        checkOutput("len_stays_max", 18, 10, 64, 1'b0);

        // Drive into the right wall: a single pulse, then the snake is frozen.
        for (int i = 0; i < 13; i++) doStep("to_wall", RIGHT, 1'b0, 1'b0);
        checkOutput("at_wall", 31, 10, 64, 1'b0);
        doStep("wall_pulse", RIGHT, 1'b0, 1'b1);
        tick();
        checkOutput("wall_pulse_ends", 31, 10, 64, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, RIGHT);
        checkOutput("dead_step_1", 31, 10, 64, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, RIGHT);
        checkOutput("dead_step_2", 31, 10, 64, 1'b0);

        // New game after death: layout restored, stale cells not reported.
        newGame("new_game_after_death");
        bus.query_x_i = 5'd14;
        bus.query_y_i = 5'd12;
        tick();
        checkQuery("query_tail_reinit", 1'b1);
        bus.query_x_i = 5'd31;
        bus.query_y_i = 5'd10;
        tick();
        checkQuery("query_stale_cell", 1'b0);

        // Length 5: up, left, down runs the head into segment 3.
        newGame("new_game_3");
        doStep("sh_grow1", RIGHT, 1'b1, 1'b0);
        doStep("sh_grow2", RIGHT, 1'b1, 1'b0);
        doStep("sh_up", UP, 1'b0, 1'b0);
        doStep("sh_left", LEFT, 1'b0, 1'b0);
        doStep("self_hit", DOWN, 1'b0, 1'b1);
        tick();
        checkOutput("self_hit_pulse_ends", 17, 11, 5, 1'b0);

        // Length 4: close a 2x2 loop into the vacating tail, which is legal.
        newGame("new_game_4");
        doStep("loop_grow", RIGHT, 1'b1, 1'b0);
        doStep("loop_up", UP, 1'b0, 1'b0);
        doStep("loop_left", LEFT, 1'b0, 1'b0);
        doStep("loop_into_tail", DOWN, 1'b0, 1'b0);
        doStep("loop_down_again", DOWN, 1'b0, 1'b0);

        // Reset together with a step: reset wins and the direction is RIGHT again.
        reset_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, DOWN);
        reset_i = 1'b0;
        checkOutput("reset_beats_step", 16, 12, 3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, RIGHT);
        checkOutput("step_after_reset", 17, 12, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
